// File: rtl/ddr2_pkg.sv
// ddr2_pkg: shared FSM encoding, default widths and the address-to-pattern function
// used by both the pattern writer and the read checker.
package ddr2_pkg;
  localparam int DEF_ADDR_WIDTH = 26;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, DELAY, REQ, DATA, NEXT, DONE} rd_state_t;
  function automatic logic [63:0] expected_data(input logic [63:0] addr);
    return addr;
  endfunction
endpackage

// File: rtl/ddr2_rd_checker_if.sv
// ddr2_rd_checker_if: user read port between the read checker (master) and the controller (slave).
interface ddr2_rd_checker_if import ddr2_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_burst_len;
  logic                  rd_ack;
  logic                  rd_data_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  modport master (output rd_req, rd_addr, rd_burst_len, input rd_ack, rd_data_valid, rd_data);
  modport slave (input rd_req, rd_addr, rd_burst_len, output rd_ack, rd_data_valid, rd_data);
endinterface

// File: rtl/ddr2_pattern_gen.sv
// ddr2_pattern_gen: maps a word address to the pattern word the writer stored there.
module ddr2_pattern_gen import ddr2_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data
);
  assign o_data = DATA_WIDTH'(expected_data(64'(i_addr)));
endmodule

// File: rtl/ddr2_rd_checker.sv
// ddr2_rd_checker: sequential burst reader that checks every beat against the writer's pattern.
// Define RD_CHK_FAIL_CAPTURE_EN to record address/data of the first failing beat.
module ddr2_rd_checker import ddr2_pkg::*; #(
  parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [7:0] RBURST_LEN = 8'd8,
  parameter int         RD_DELAY   = 200,
  parameter int         ADDR_END   = 1024,
  parameter int         TIMEOUT    = 1023
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  init_end,
  input  logic                  wr_over,
  ddr2_rd_checker_if.master     rd_if,
  output logic                  rd_error,
  output logic                  rd_done,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);
  rd_state_t             r_state;
  logic [15:0]           r_cnt;
  logic [7:0]            r_beat;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_req;
  logic [7:0]            w_beat;
  logic [ADDR_WIDTH-1:0] w_beat_addr, w_next_base;
  logic [DATA_WIDTH-1:0] w_exp;
  logic                  w_ack, w_check, w_last, w_mismatch, w_proto, w_tmo, w_err;
  assign rd_if.rd_req       = r_req;
  assign rd_if.rd_addr      = r_base;
  assign rd_if.rd_burst_len = RBURST_LEN;
  // a beat arriving with the grant counts as beat 0 of the burst
  assign w_ack       = r_state == REQ && rd_if.rd_ack;
  assign w_check     = rd_if.rd_data_valid && (r_state == DATA || w_ack);
  assign w_beat      = r_state == DATA ? r_beat : 8'd0;
  assign w_beat_addr = r_base + ADDR_WIDTH'(w_beat);
  assign w_next_base = r_base + ADDR_WIDTH'(RBURST_LEN);
  assign w_last      = w_check && w_beat == RBURST_LEN - 8'd1;
  assign w_mismatch  = w_check && rd_if.rd_data != w_exp;
  assign w_proto     = rd_if.rd_data_valid && !w_check && r_state != IDLE;
  assign w_tmo       = ((r_state == REQ && !rd_if.rd_ack) || (r_state == DATA && !rd_if.rd_data_valid))
                       && r_cnt == 16'(TIMEOUT - 1);
  assign w_err       = w_mismatch || w_proto || w_tmo;
  ddr2_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pat (
    .i_addr(w_beat_addr),
    .o_data(w_exp)
  );
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_base  <= '0;
      r_req   <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (init_end && wr_over) begin
          r_state <= DELAY;
          r_cnt   <= '0;
        end
        DELAY: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == 16'(RD_DELAY - 1)) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (rd_if.rd_ack) begin
            r_req   <= 1'b0;
            r_cnt   <= '0;
            r_beat  <= {7'd0, w_check};
            r_state <= w_last ? NEXT : DATA;
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_state <= NEXT;
          end
        end
        DATA: begin
          r_cnt <= w_check ? 16'd0 : r_cnt + 16'd1;
          if (w_check) r_beat <= r_beat + 8'd1;
          if (w_last || w_tmo) r_state <= NEXT;
        end
        NEXT: begin
          r_base  <= w_next_base;
          r_cnt   <= '0;
          r_state <= w_next_base == ADDR_WIDTH'(ADDR_END) ? DONE : DELAY;
        end
        default: rd_done <= 1'b1;
      endcase
    end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      rd_error <= 1'b0;
      err_cnt  <= '0;
    end else if (w_err) begin
      rd_error <= 1'b1;
      err_cnt  <= err_cnt + {15'd0, err_cnt != 16'hFFFF};
    end
`ifdef RD_CHK_FAIL_CAPTURE_EN
  logic r_cap;
  // frozen after the first mismatch or timeout; protocol errors carry no address
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_cap     <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (!r_cap && (w_mismatch || w_tmo)) begin
      r_cap     <= 1'b1;
      fail_addr <= w_mismatch ? w_beat_addr : r_base;
      fail_data <= w_mismatch ? rd_if.rd_data : '0;
    end
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif
endmodule

// File: tb/tb_ddr2_rd_checker.sv
// tb_ddr2_rd_checker: directed scenarios against a hand-driven controller read port.
module tb_ddr2_rd_checker;
  localparam int AW = 26, DW = 32, RB = 8, RDD = 4, AEND = 32, TMO = 15;
  logic clk = 1'b0, rst = 1'b1, init_end = 1'b0, wr_over = 1'b0;
  logic rd_error, rd_done;
  logic [15:0] err_cnt;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  int tests = 0, fails = 0;
  ddr2_rd_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ddr2_rd_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RBURST_LEN(8'(RB)), .RD_DELAY(RDD),
    .ADDR_END(AEND), .TIMEOUT(TMO)) dut (
    .sys_clk(clk), .sys_rst(rst), .init_end(init_end), .wr_over(wr_over), .rd_if(bus),
    .rd_error(rd_error), .rd_done(rd_done), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; init_end = 1'b0; wr_over = 1'b0;
    bus.rd_ack = 1'b0; bus.rd_data_valid = 1'b0; bus.rd_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // waits for a request, grants it after lat cycles (lat<0: never) and returns the burst
  task automatic serve_burst(input int lat, input int bad_a, input logic [31:0] bad_v, input int drop,
                             output logic [AW-1:0] addr, output logic got, output logic hs_ok,
                             output logic e_bef, output logic e_aft);
    int n;
    logic prev_bad;
    got = 1'b0; hs_ok = 1'b1; e_bef = 1'b0; e_aft = 1'b0; addr = '0; prev_bad = 1'b0; n = 0;
    while (!bus.rd_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rd_req) return;
    got = 1'b1;
    addr = bus.rd_addr;
    if (lat < 0) return;
    repeat (lat) begin
      @(negedge clk);
      hs_ok &= bus.rd_req && bus.rd_addr == addr;
    end
    bus.rd_ack = 1'b1;
    for (int i = 0; i <= RB; i++) begin
      @(negedge clk);
      bus.rd_ack = 1'b0;
      if (i == 0) hs_ok &= !bus.rd_req;
      if (prev_bad) e_aft = rd_error;
      prev_bad = 1'b0;
      if (i < RB && i < drop) begin
        bus.rd_data_valid = 1'b1;
        bus.rd_data = (32'(addr) + 32'(i) == 32'(bad_a)) ? bad_v : 32'(addr) + 32'(i);
        if (32'(addr) + 32'(i) == 32'(bad_a)) begin
          prev_bad = 1'b1;
          e_bef = rd_error;
        end
      end else bus.rd_data_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !rd_done; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.rd_ack = 1'b0; bus.rd_data_valid = 1'b0; bus.rd_data = '0;
    repeat (2) @(negedge clk);
    tests++; if (bus.rd_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.rd_req); end
    tests++; if (bus.rd_addr !== '0) begin fails++; $display("FAIL reset_addr: got %0h want 0", bus.rd_addr); end
    tests++; if (rd_error !== 1'b0 || rd_done !== 1'b0) begin fails++; $display("FAIL reset_flags: got err=%b done=%b want 0 0", rd_error, rd_done); end
    tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    tests++; if (bus.rd_burst_len !== 8'(RB)) begin fails++; $display("FAIL burst_len: got %0d want %0d", bus.rd_burst_len, RB); end
    tests++; if (fail_addr !== '0 || fail_data !== '0) begin fails++; $display("FAIL reset_fail_regs: got %0h/%0h want 0/0", fail_addr, fail_data); end
    rst = 1'b0;
    wr_over = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (bus.rd_req !== 1'b0) begin fails++; $display("FAIL idle_wait: got req=%b want 0 without init_end", bus.rd_req); end
  endtask

  task automatic test_pass();
    logic [AW-1:0] a;
    logic got, hs, eb, ea;
    do_reset();
    init_end = 1'b1; wr_over = 1'b1;
    for (int b = 0; b < AEND / RB; b++) begin
      serve_burst(3, -1, 32'h0, RB, a, got, hs, eb, ea);
      if (b == 0) init_end = 1'b0;
      tests++; if (!got || a !== AW'(b * RB)) begin fails++; $display("FAIL pass_addr%0d: got %0d (req=%b) want %0d", b, a, got, b * RB); end
      tests++; if (!hs) begin fails++; $display("FAIL pass_handshake%0d: got bad req hold/drop want clean", b); end
    end
    wait_done();
    tests++; if (rd_done !== 1'b1) begin fails++; $display("FAIL pass_done: got %b want 1", rd_done); end
    tests++; if (rd_error !== 1'b0 || err_cnt !== 16'd0) begin fails++; $display("FAIL pass_clean: got err=%b cnt=%0d want 0 0", rd_error, err_cnt); end
    repeat (20) @(negedge clk);
    tests++; if (bus.rd_req !== 1'b0 || rd_done !== 1'b1) begin fails++; $display("FAIL done_hold: got req=%b done=%b want 0 1", bus.rd_req, rd_done); end
  endtask

  task automatic test_mismatch();
    logic [AW-1:0] a;
    logic got, hs, eb, ea, e_bef, e_aft;
    do_reset();
    init_end = 1'b1; wr_over = 1'b1;
    e_bef = 1'b1; e_aft = 1'b0;
    for (int b = 0; b < AEND / RB; b++) begin
      serve_burst(3, 13, 32'hDEAD, RB, a, got, hs, eb, ea);
      if (b == 1) begin e_bef = eb; e_aft = ea; end
    end
    tests++; if (e_bef !== 1'b0 || e_aft !== 1'b1) begin fails++; $display("FAIL mm_timing: got before=%b after=%b want 0 1", e_bef, e_aft); end
    wait_done();
    tests++; if (rd_done !== 1'b1) begin fails++; $display("FAIL mm_done: got %b want 1", rd_done); end
    tests++; if (rd_error !== 1'b1 || err_cnt !== 16'd1) begin fails++; $display("FAIL mm_count: got err=%b cnt=%0d want 1 1", rd_error, err_cnt); end
`ifdef RD_CHK_FAIL_CAPTURE_EN
    tests++; if (fail_addr !== AW'(13) || fail_data !== 32'hDEAD) begin fails++; $display("FAIL mm_capture: got %0h/%0h want d/dead", fail_addr, fail_data); end
`else
    tests++; if (fail_addr !== '0 || fail_data !== '0) begin fails++; $display("FAIL mm_capture: got %0h/%0h want 0/0", fail_addr, fail_data); end
`endif
  endtask

  task automatic test_no_ack();
    logic [AW-1:0] a;
    logic got, hs, eb, ea;
    int n;
    do_reset();
    init_end = 1'b1; wr_over = 1'b1;
    for (int b = 0; b < AEND / RB; b++) begin
      serve_burst(-1, -1, 32'h0, RB, a, got, hs, eb, ea);
      n = got ? 1 : 0;
      for (int i = 0; i < 100 && got; i++) begin
        @(negedge clk);
        if (bus.rd_req) n++; else break;
      end
      tests++; if (!got || a !== AW'(b * RB)) begin fails++; $display("FAIL tmo_addr%0d: got %0d want %0d", b, a, b * RB); end
      tests++; if (n != TMO) begin fails++; $display("FAIL tmo_len%0d: got %0d req cycles want %0d", b, n, TMO); end
      tests++; if (rd_error !== 1'b1 || err_cnt !== 16'(b + 1)) begin fails++; $display("FAIL tmo_cnt%0d: got err=%b cnt=%0d want 1 %0d", b, rd_error, err_cnt, b + 1); end
    end
    wait_done();
    tests++; if (rd_done !== 1'b1 || err_cnt !== 16'd4) begin fails++; $display("FAIL tmo_done: got done=%b cnt=%0d want 1 4", rd_done, err_cnt); end
  endtask

  task automatic test_drop();
    logic [AW-1:0] a;
    logic got, hs, eb, ea;
    do_reset();
    init_end = 1'b1; wr_over = 1'b1;
    serve_burst(3, -1, 32'h0, 6, a, got, hs, eb, ea);
    serve_burst(3, -1, 32'h0, RB, a, got, hs, eb, ea);
    tests++; if (!got || a !== AW'(8)) begin fails++; $display("FAIL drop_next_addr: got %0d want 8", a); end
    tests++; if (rd_error !== 1'b1 || err_cnt !== 16'd1) begin fails++; $display("FAIL drop_cnt: got err=%b cnt=%0d want 1 1", rd_error, err_cnt); end
    for (int b = 2; b < AEND / RB; b++) serve_burst(3, -1, 32'h0, RB, a, got, hs, eb, ea);
    wait_done();
    tests++; if (rd_done !== 1'b1 || err_cnt !== 16'd1) begin fails++; $display("FAIL drop_done: got done=%b cnt=%0d want 1 1", rd_done, err_cnt); end
  endtask

  task automatic test_stray();
    logic [AW-1:0] a;
    logic got, hs, eb, ea;
    do_reset();
    bus.rd_data_valid = 1'b1; bus.rd_data = 32'h5; bus.rd_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.rd_data_valid = 1'b0; bus.rd_ack = 1'b0;
    @(negedge clk);
    tests++; if (rd_error !== 1'b0 || err_cnt !== 16'd0) begin fails++; $display("FAIL stray_idle: got err=%b cnt=%0d want 0 0", rd_error, err_cnt); end
    init_end = 1'b1; wr_over = 1'b1;
    @(negedge clk);
    bus.rd_data_valid = 1'b1; bus.rd_data = 32'h0;
    @(negedge clk);
    bus.rd_data_valid = 1'b0; bus.rd_ack = 1'b1;
    tests++; if (rd_error !== 1'b1 || err_cnt !== 16'd1) begin fails++; $display("FAIL stray_delay: got err=%b cnt=%0d want 1 1", rd_error, err_cnt); end
    @(negedge clk);
    bus.rd_ack = 1'b0;
    serve_burst(3, -1, 32'h0, RB, a, got, hs, eb, ea);
    tests++; if (!got || !hs || a !== '0) begin fails++; $display("FAIL stray_ack_ignored: got addr=%0d hs=%b want 0 1", a, hs); end
    tests++; if (err_cnt !== 16'd1) begin fails++; $display("FAIL stray_after: got cnt=%0d want 1", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    logic got, hs, eb, ea;
    do_reset();
    init_end = 1'b1; wr_over = 1'b1;
    serve_burst(3, 2, 32'h0, RB, a, got, hs, eb, ea);
    serve_burst(-1, -1, 32'h0, RB, a, got, hs, eb, ea);
    tests++; if (!got || a !== AW'(8) || err_cnt !== 16'd1) begin fails++; $display("FAIL rm_pre: got addr=%0d cnt=%0d want 8 1", a, err_cnt); end
    repeat (3) @(negedge clk);
    bus.rd_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.rd_ack = 1'b0; bus.rd_data_valid = 1'b1; bus.rd_data = 32'(8 + i);
    end
    #2 rst = 1'b1; init_end = 1'b0; wr_over = 1'b0;
    #1;
    tests++; if (bus.rd_req !== 1'b0 || bus.rd_addr !== '0) begin fails++; $display("FAIL rm_async_bus: got req=%b addr=%0d want 0 0", bus.rd_req, bus.rd_addr); end
    tests++; if (rd_error !== 1'b0 || err_cnt !== 16'd0 || rd_done !== 1'b0) begin fails++; $display("FAIL rm_async_flags: got err=%b cnt=%0d done=%b want 0 0 0", rd_error, err_cnt, rd_done); end
    for (int i = 4; i < RB; i++) begin
      @(negedge clk);
      rst = 1'b0; bus.rd_data = 32'(8 + i);
    end
    @(negedge clk);
    bus.rd_data_valid = 1'b0;
    tests++; if (rd_error !== 1'b0 || err_cnt !== 16'd0) begin fails++; $display("FAIL rm_idle_beats: got err=%b cnt=%0d want 0 0", rd_error, err_cnt); end
    init_end = 1'b1; wr_over = 1'b1;
    for (int b = 0; b < AEND / RB; b++) begin
      serve_burst(3, -1, 32'h0, RB, a, got, hs, eb, ea);
      if (b == 0) begin
        tests++; if (!got || a !== '0) begin fails++; $display("FAIL rm_restart_addr: got %0d want 0", a); end
      end
    end
    wait_done();
    tests++; if (rd_done !== 1'b1 || err_cnt !== 16'd0) begin fails++; $display("FAIL rm_done: got done=%b cnt=%0d want 1 0", rd_done, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_no_ack();
    test_drop();
    test_stray();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
